keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry_if.sv | 21 ++
 rtl/keypad_entry.sv | 245 ++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// Keypad scanner interface: matrix lines plus the decoded entry outputs.
// The master side is the scanner; the slave side is the keypad/display.
interface keypad_entry_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [11:0] value;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        enter;
  logic        reject;

  modport master (
    input  row,
    output col, value, key_valid, key_code, enter, reject
  );

  modport slave (
    output row,
    input  col, value, key_valid, key_code, enter, reject
  );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and a decimal entry accumulator.
// It applies clear, backspace and enter keys, and refuses any digit that would overflow 4095.
module keypad_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  keypad_entry_if.master kp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESS    = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  function automatic logic [3:0] col_decode(input logic [1:0] idx);
    logic [3:0] res;
    res = 4'hF;
    res[idx] = 1'b0;
    return res;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rows[i] == 1'b0) begin
        res = 2'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] res;
    case ({r, c})
      4'b00_00: res = 4'h1;
      4'b00_01: res = 4'h2;
      4'b00_10: res = 4'h3;
      4'b00_11: res = 4'hA;
      4'b01_00: res = 4'h4;
      4'b01_01: res = 4'h5;
      4'b01_10: res = 4'h6;
      4'b01_11: res = 4'hB;
      4'b10_00: res = 4'h7;
      4'b10_01: res = 4'h8;
      4'b10_10: res = 4'h9;
      4'b10_11: res = 4'hC;
      4'b11_00: res = 4'hE;
      4'b11_01: res = 4'h0;
      4'b11_10: res = 4'hF;
      4'b11_11: res = 4'hD;
      default:  res = 4'h0;
    endcase
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        row_meta_q, row_sync_q;
  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        col_q, col_d;
  logic [3:0]        cand_row_q, cand_row_d;
  logic [1:0]        cand_r_q, cand_r_d;
  logic [DB_W-1:0]   match_cnt_q, match_cnt_d;
  logic [11:0]       value_q, value_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              enter_q, enter_d;
  logic              reject_q, reject_d;

  logic              tick_s;
  logic              detect_s;
  logic              press_go_s;
  logic [1:0]        press_r_s;
  logic [3:0]        press_code_s;
  logic [DB_W-1:0]   match_inc_s;
  logic [15:0]       digit_sum_s;

  // Next-state, scan timing and entry arithmetic.
  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q + CNT_W'(1);
    col_idx_d   = col_idx_q;
    cand_row_d  = cand_row_q;
    cand_r_d    = cand_r_q;
    match_cnt_d = match_cnt_q;
    value_d     = value_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    enter_d     = 1'b0;
    reject_d    = 1'b0;
    press_go_s  = 1'b0;
    press_r_s   = cand_r_q;

    tick_s      = (scan_cnt_q == CNT_LAST);
    detect_s    = (row_sync_q != 4'hF);
    match_inc_s = match_cnt_q + DB_W'(1);

    if (tick_s) begin
      scan_cnt_d = '0;
    end else begin
      scan_cnt_d = scan_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_SCAN: begin
        if (tick_s && detect_s) begin
          cand_row_d  = row_sync_q;
          cand_r_d    = low_index(row_sync_q);
          press_r_s   = low_index(row_sync_q);
          match_cnt_d = DB_W'(1);
          if (DB_TARGET <= DB_W'(1)) begin
            press_go_s = 1'b1;
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end else if (tick_s) begin
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DEBOUNCE: begin
        if (tick_s && (row_sync_q == cand_row_q)) begin
          match_cnt_d = match_inc_s;
          if (match_inc_s >= DB_TARGET) begin
            press_go_s = 1'b1;
          end else begin
            state_d = ST_DEBOUNCE;
          end
        end else if (tick_s) begin
          state_d   = ST_SCAN;
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          state_d = ST_DEBOUNCE;
        end
      end
      ST_PRESS: begin
        state_d     = ST_RELEASE;
        match_cnt_d = '0;
      end
      ST_RELEASE: begin
        // Any low row restarts the release count, so a held key never repeats.
        if (tick_s && !detect_s) begin
          if (match_inc_s >= DB_TARGET) begin
            state_d     = ST_SCAN;
            col_idx_d   = col_idx_q + 2'd1;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_inc_s;
          end
        end else if (tick_s) begin
          match_cnt_d = '0;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d   = ST_SCAN;
        col_idx_d = 2'd0;
      end
    endcase

    press_code_s = key_map(press_r_s, col_idx_q);
    digit_sum_s  = ({4'd0, value_q} << 3) + ({4'd0, value_q} << 1) + {12'd0, press_code_s};

    if (press_go_s) begin
      state_d     = ST_PRESS;
      key_valid_d = 1'b1;
      key_code_d  = press_code_s;
      case (press_code_s)
        4'hA:    value_d = 12'd0;
        4'hB:    value_d = value_q / 12'd10;
        4'hC:    enter_d = 1'b1;
        4'hD, 4'hE, 4'hF: value_d = value_q;
        default: begin
          if (digit_sum_s <= 16'd4095) begin
            value_d = digit_sum_s[11:0];
          end else begin
            reject_d = 1'b1;
          end
        end
      endcase
    end else begin
      key_valid_d = 1'b0;
    end

    col_d = col_decode(col_idx_d);
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      scan_cnt_q  <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      cand_row_q  <= 4'hF;
      cand_r_q    <= 2'd0;
      match_cnt_q <= '0;
      value_q     <= 12'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      enter_q     <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_meta_q  <= kp.row;
      row_sync_q  <= row_meta_q;
      scan_cnt_q  <= scan_cnt_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      cand_r_q    <= cand_r_d;
      match_cnt_q <= match_cnt_d;
      value_q     <= value_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      enter_q     <= enter_d;
      reject_q    <= reject_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.value     = value_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.enter     = enter_q;
  assign kp.reject    = reject_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a keypad model closes row/column contacts
// and each accepted key is compared against hand-computed codes and values.
module tb_keypad_entry;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   kv_cnt;
  int   en_cnt;
  int   rj_cnt;

  logic       k0_en, k1_en;
  logic [1:0] k0_r, k0_c, k1_r, k1_c;
  logic [3:0] row_drv;

  logic [11:0] v;
  logic [3:0]  code;
  logic        en, rj;
  logic [3:0]  col_after;
  int          kv_before;
  logic [3:0]  prev_col;
  logic        got;

  keypad_entry_if kp ();

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad contacts: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_drv = 4'hF;
    if (k0_en && kp.col[k0_c] == 1'b0) row_drv[k0_r] = 1'b0;
    if (k1_en && kp.col[k1_c] == 1'b0) row_drv[k1_r] = 1'b0;
  end
  assign kp.row = row_drv;

  always @(posedge clk) begin
    if (kp.key_valid) kv_cnt <= kv_cnt + 1;
    if (kp.enter)     en_cnt <= en_cnt + 1;
    if (kp.reject)    rj_cnt <= rj_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [1:0] r, input logic [1:0] c, input int hold_ticks,
                           output logic [11:0] pv, output logic [3:0] pcode,
                           output logic pen, output logic prj, output logic [3:0] pcol);
    logic       seen;
    logic [3:0] frozen;
    seen = 1'b0; pv = 12'd0; pcode = 4'd0; pen = 1'b0; prj = 1'b0;
    k0_r = r; k0_c = c; k0_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (kp.key_valid) begin
        seen = 1'b1; pv = kp.value; pcode = kp.key_code; pen = kp.enter; prj = kp.reject;
        break;
      end
    end
    check("kv_seen", 16'(seen), 16'd1);
    frozen = kp.col;
    pcol = frozen;
    repeat (hold_ticks * 4) @(negedge clk);
    k0_en = 1'b0;
    k1_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kp.col != frozen) begin
        pcol = kp.col;
        break;
      end
    end
  endtask

  task automatic tap(input string tag, input logic [1:0] r, input logic [1:0] c,
                     input logic [3:0] exp_code, input logic [11:0] exp_val,
                     input logic exp_en, input logic exp_rj);
    logic [11:0] tv;
    logic [3:0]  tc, tcol;
    logic        te, tr;
    press_key(r, c, 1, tv, tc, te, tr, tcol);
    check({tag, "_code"}, 16'(tc), 16'(exp_code));
    check({tag, "_value"}, 16'(tv), 16'(exp_val));
    check({tag, "_enter"}, 16'(te), 16'(exp_en));
    check({tag, "_reject"}, 16'(tr), 16'(exp_rj));
  endtask

  task automatic wait_col_enter(input logic [3:0] target);
    logic ok;
    logic [3:0] prev;
    ok = 1'b0;
    prev = kp.col;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kp.col == target && prev != target) begin
        ok = 1'b1;
        break;
      end
      prev = kp.col;
    end
    check("col_align", 16'(ok), 16'd1);
  endtask

  initial begin
    checks = 0; errors = 0; kv_cnt = 0; en_cnt = 0; rj_cnt = 0;
    k0_en = 1'b0; k1_en = 1'b0; k0_r = 2'd0; k0_c = 2'd0; k1_r = 2'd0; k1_c = 2'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 16'(kp.col), 16'h000E);
    check("rst_value", 16'(kp.value), 16'd0);
    check("rst_code", 16'(kp.key_code), 16'd0);
    check("rst_pulses", 16'({kp.key_valid, kp.enter, kp.reject}), 16'd0);
    rst_n = 1'b1;

    // Key 5 held for 20 ticks: one acceptance, then scanning resumes at column 2.
    kv_before = kv_cnt;
    press_key(2'd1, 2'd1, 20, v, code, en, rj, col_after);
    check("k5_code", 16'(code), 16'h5);
    check("k5_value", 16'(v), 16'd5);
    check("k5_norepeat", 16'(kv_cnt - kv_before), 16'd1);
    check("k5_col_resume", 16'(col_after), 16'h000B);

    tap("clr0", 2'd0, 2'd3, 4'hA, 12'd0, 1'b0, 1'b0);
    tap("d4", 2'd1, 2'd0, 4'h4, 12'd4, 1'b0, 1'b0);
    tap("d0", 2'd3, 2'd1, 4'h0, 12'd40, 1'b0, 1'b0);
    tap("d9", 2'd2, 2'd2, 4'h9, 12'd409, 1'b0, 1'b0);
    tap("d5", 2'd1, 2'd1, 4'h5, 12'd4095, 1'b0, 1'b0);
    tap("ovf1", 2'd0, 2'd0, 4'h1, 12'd4095, 1'b0, 1'b1);

    tap("clr1", 2'd0, 2'd3, 4'hA, 12'd0, 1'b0, 1'b0);
    tap("e1", 2'd0, 2'd0, 4'h1, 12'd1, 1'b0, 1'b0);
    tap("e2", 2'd0, 2'd1, 4'h2, 12'd12, 1'b0, 1'b0);
    tap("e3", 2'd0, 2'd2, 4'h3, 12'd123, 1'b0, 1'b0);
    tap("bs1", 2'd1, 2'd3, 4'hB, 12'd12, 1'b0, 1'b0);
    tap("clr2", 2'd0, 2'd3, 4'hA, 12'd0, 1'b0, 1'b0);
    tap("bs0", 2'd1, 2'd3, 4'hB, 12'd0, 1'b0, 1'b0);
    tap("ent", 2'd2, 2'd3, 4'hC, 12'd0, 1'b1, 1'b0);
    tap("star", 2'd3, 2'd0, 4'hE, 12'd0, 1'b0, 1'b0);
    tap("hash", 2'd3, 2'd2, 4'hF, 12'd0, 1'b0, 1'b0);

    // Bounce: key 7 seen on two ticks, gone on the third.
    kv_before = kv_cnt;
    wait_col_enter(4'b1110);
    k0_r = 2'd2; k0_c = 2'd0; k0_en = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    k0_en = 1'b0;
    prev_col = kp.col;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kp.col != prev_col) begin
        got = 1'b1;
        break;
      end
    end
    check("bounce_advanced", 16'(got), 16'd1);
    check("bounce_col", 16'(kp.col), 16'h000D);
    check("bounce_nokv", 16'(kv_cnt - kv_before), 16'd0);

    // Two keys in column 0: the lowest row wins.
    k1_r = 2'd2; k1_c = 2'd0; k1_en = 1'b1;
    press_key(2'd0, 2'd0, 1, v, code, en, rj, col_after);
    check("multi_code", 16'(code), 16'h1);
    check("multi_value", 16'(v), 16'd1);

    // Reset in the middle of debounce with value 77.
    tap("clr3", 2'd0, 2'd3, 4'hA, 12'd0, 1'b0, 1'b0);
    tap("s7a", 2'd2, 2'd0, 4'h7, 12'd7, 1'b0, 1'b0);
    tap("s7b", 2'd2, 2'd0, 4'h7, 12'd77, 1'b0, 1'b0);
    kv_before = kv_cnt;
    wait_col_enter(4'b1101);
    k0_r = 2'd1; k0_c = 2'd1; k0_en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_value", 16'(kp.value), 16'd0);
    check("mid_rst_col", 16'(kp.col), 16'h000E);
    check("mid_rst_code", 16'(kp.key_code), 16'd0);
    check("mid_rst_pulses", 16'({kp.key_valid, kp.enter, kp.reject}), 16'd0);
    check("mid_rst_nokv", 16'(kv_cnt - kv_before), 16'd0);
    rst_n = 1'b1;

    // Key held through reset is accepted as a fresh press.
    press_key(2'd1, 2'd1, 1, v, code, en, rj, col_after);
    check("held_code", 16'(code), 16'h5);
    check("held_value", 16'(v), 16'd5);

    check("enter_total", 16'(en_cnt), 16'd1);
    check("reject_total", 16'(rj_cnt), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
